rv64reg_mp: RTL and testbench

RV64REG_MP -- requirements
Module: rv64reg_mp

---
 rtl/rv64reg_mp.sv | 146 ++++++++++++++
 tb/tb_rv64reg_mp.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64reg_mp.sv
// rv64reg_mp -- multi-ported integer register file with a per-register busy
// scoreboard and a self-clearing initialisation sequence.
//
// After reset the block walks every entry once, zeroing data and busy, and
// only then begins accepting writes (init_done high). Entry 0 is hardwired to
// read as zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a RUN read of an index being written this cycle returns the
//                incoming write data (highest-numbered matching port) and
//                reports not-busy.
//   undefined -> reads see the stored value; new data appears next cycle.
module rv64reg_mp #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  parameter  int NR   = 2,
  parameter  int NW   = 1,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR*AW-1:0]  rd_idx,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]     rd_busy,
  input  logic [NW-1:0]     wr_en,
  input  logic [NW*AW-1:0]  wr_idx,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_idx,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   cnt_r;
  logic [AW-1:0]   cnt_s;
  logic [XLEN-1:0] mem_r [NREG];
  logic [NREG-1:0] busy_r;
  logic            run_s;

  // Reads and writes are only live in RUN and never while reset is held,
  // so outputs go quiet in the same cycle rst rises.
  assign run_s     = (state_r == ST_RUN) && !rst;
  assign init_done = run_s;

  // FSM state and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= IDX_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: step through every entry once, then settle in RUN.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == IDX_LAST) begin
          state_s = ST_RUN;
          cnt_s   = IDX_ZERO;
        end else begin
          state_s = ST_INIT;
          cnt_s   = cnt_r + IDX_ONE;
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
        cnt_s   = cnt_r;
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = IDX_ZERO;
      end
    endcase
  end

  // Storage update: clear one entry per INIT cycle, otherwise apply writes in
  // ascending port order so the highest port wins, then let a scoreboard set
  // override any same-cycle busy clear.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_INIT)) begin
      mem_r[cnt_r]  <= {XLEN{1'b0}};
      busy_r[cnt_r] <= 1'b0;
    end else if (!rst && (state_r == ST_RUN)) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && (wr_idx[w*AW +: AW] != IDX_ZERO)) begin
          mem_r[wr_idx[w*AW +: AW]]  <= wr_data[w*XLEN +: XLEN];
          busy_r[wr_idx[w*AW +: AW]] <= 1'b0;
        end
      end
      if (sb_set_en && (sb_set_idx != IDX_ZERO)) begin
        busy_r[sb_set_idx] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0]   idx_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign idx_s = rd_idx[p*AW +: AW];

    // Combinational read port: zero outside RUN and for index 0.
    always_comb begin
      data_s = {XLEN{1'b0}};
      busy_s = 1'b0;
      if (run_s && (idx_s != IDX_ZERO)) begin
        data_s = mem_r[idx_s];
        busy_s = busy_r[idx_s];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w] && (wr_idx[w*AW +: AW] == idx_s)) begin
            data_s = wr_data[w*XLEN +: XLEN];
            busy_s = 1'b0;
          end else begin
            data_s = data_s;
            busy_s = busy_s;
          end
        end
`endif
      end else begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_s;
    assign rd_busy[p]              = busy_s;
  end

endmodule

// File: tb/tb_rv64reg_mp.sv
// Self-checking bench for rv64reg_mp (XLEN=64, NREG=32, NR=2, NW=2).
// A behavioural model tracks register contents, busy flags and the number of
// clear cycles completed since reset; expected reads are derived from it.
module tb_rv64reg_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NR*AW-1:0]   rd_idx;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_idx;
  logic [NW*XLEN-1:0] wr_data;
  logic               sb_set_en;
  logic [AW-1:0]      sb_set_idx;
  logic               init_done;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [63:0] m_mem [NREG];
  logic        m_busy [NREG];
  int          m_cleared;   // entries cleared since rst went low

  rv64reg_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .sb_set_en  (sb_set_en),
    .sb_set_idx (sb_set_idx),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_running();
    return (rst == 1'b0) && (m_cleared >= NREG);
  endfunction

  // expected read result for an index given the current inputs
  function automatic void m_read(input int idx, output logic [63:0] d, output logic b);
    d = 64'd0;
    b = 1'b0;
    if (m_running() && idx != 0) begin
      d = m_mem[idx];
      b = m_busy[idx];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && int'(wr_idx[w*AW +: AW]) == idx) begin
          d = wr_data[w*XLEN +: XLEN];
          b = 1'b0;
        end
      end
`endif
    end
  endfunction

  // advance one clock edge, updating the model from the inputs in force
  task automatic cycle();
    if (rst) begin
      m_cleared = 0;
    end else if (m_cleared < NREG) begin
      m_mem[m_cleared]  = 64'd0;
      m_busy[m_cleared] = 1'b0;
      m_cleared++;
    end else begin
      for (int w = 0; w < NW; w++) begin
        int i;
        i = int'(wr_idx[w*AW +: AW]);
        if (wr_en[w] && i != 0) begin
          m_mem[i]  = wr_data[w*XLEN +: XLEN];
          m_busy[i] = 1'b0;
        end
      end
      if (sb_set_en && sb_set_idx != 5'd0) m_busy[int'(sb_set_idx)] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en      = 2'b00;
    wr_idx     = 10'd0;
    wr_data    = 128'd0;
    sb_set_en  = 1'b0;
    sb_set_idx = 5'd0;
    rd_idx     = 10'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (init_done !== 1'b0) begin
      $display("FAIL reset_init_done got %0b want 0", init_done);
      errors++;
    end
    rst = 1'b0;
    for (int c = 0; c < NREG; c++) begin
      // noise on write/set ports must be ignored during the clear
      wr_en      = 2'($urandom_range(0, 3));
      wr_idx     = 10'($urandom);
      wr_data    = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      sb_set_en  = 1'($urandom_range(0, 1));
      sb_set_idx = 5'($urandom);
      rd_idx     = 10'($urandom);
      #1;
      checks++;
      if (init_done !== 1'b0 || rd_data !== 128'd0 || rd_busy !== 2'b00) begin
        $display("FAIL init_quiet cyc=%0d init_done=%0b rd_data=%h rd_busy=%b want 0/0/0",
                 c, init_done, rd_data, rd_busy);
        errors++;
      end
      cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (init_done !== 1'b1) begin
      $display("FAIL init_done_after_32 got %0b want 1", init_done);
      errors++;
    end
    for (int i = 0; i < NREG; i += 2) begin
      rd_idx = {5'(i + 1), 5'(i)};
      #1;
      checks++;
      if (rd_data !== 128'd0 || rd_busy !== 2'b00) begin
        $display("FAIL cleared_read idx=%0d data=%h busy=%b want 0", i, rd_data, rd_busy);
        errors++;
      end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_data = {64'd0, 64'hDEADBEEF_00000001};
    cycle();
    idle_inputs();
    rd_idx = {5'd5, 5'd0};
    #1;
    checks++;
    if (rd_data[127:64] !== 64'hDEADBEEF_00000001) begin
      $display("FAIL x5_port1 got %h want deadbeef00000001", rd_data[127:64]);
      errors++;
    end
    wr_en = 2'b01; wr_idx = {5'd0, 5'd0}; wr_data = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    cycle();
    idle_inputs();
    rd_idx = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 128'd0 || rd_busy !== 2'b00) begin
      $display("FAIL x0_zero got %h/%b want 0", rd_data, rd_busy);
      errors++;
    end
  endtask

  task automatic test_port_priority();
    idle_inputs();
    wr_en = 2'b11; wr_idx = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
    cycle();
    idle_inputs();
    rd_idx = {5'd0, 5'd7};
    #1;
    checks++;
    if (rd_data[63:0] !== 64'h22) begin
      $display("FAIL x7_priority got %h want 22", rd_data[63:0]);
      errors++;
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    sb_set_en = 1'b1; sb_set_idx = 5'd9;
    cycle();
    idle_inputs();
    rd_idx = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_set_x9 busy got %b want 1", rd_busy[0]);
      errors++;
    end
    wr_en = 2'b01; wr_idx = {5'd0, 5'd9}; wr_data = {64'd0, 64'h99};
    cycle();
    idle_inputs();
    rd_idx = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'h99) begin
      $display("FAIL wr_clear_x9 busy=%b data=%h want 0/99", rd_busy[0], rd_data[63:0]);
      errors++;
    end
    sb_set_en = 1'b1; sb_set_idx = 5'd9;
    wr_en = 2'b10; wr_idx = {5'd9, 5'd0}; wr_data = {64'hAB, 64'd0};
    cycle();
    idle_inputs();
    rd_idx = {5'd9, 5'd0};
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1 || rd_data[127:64] !== 64'hAB) begin
      $display("FAIL set_beats_clear busy=%b data=%h want 1/ab", rd_busy[1], rd_data[127:64]);
      errors++;
    end
    sb_set_en = 1'b1; sb_set_idx = 5'd0;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      $display("FAIL sb_set_x0 busy got %b want 00", rd_busy);
      errors++;
    end
  endtask

  task automatic test_bypass();
    logic [63:0] want;
    idle_inputs();
    wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {64'd0, 64'h33};
    cycle();
    wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {64'd0, 64'h55};
    rd_idx = {5'd3, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 64'h55;
`else
    want = 64'h33;
`endif
    checks++;
    if (rd_data[63:0] !== want || rd_data[127:64] !== want) begin
      $display("FAIL same_cycle_x3 got %h/%h want %h", rd_data[63:0], rd_data[127:64], want);
      errors++;
    end
    cycle();
    idle_inputs();
    rd_idx = {5'd0, 5'd3};
    #1;
    checks++;
    if (rd_data[63:0] !== 64'h55) begin
      $display("FAIL next_cycle_x3 got %h want 55", rd_data[63:0]);
      errors++;
    end
  endtask

  task automatic test_random();
    logic [63:0] ed;
    logic        eb;
    for (int c = 0; c < 400; c++) begin
      wr_en      = 2'($urandom_range(0, 3));
      wr_idx     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      wr_data    = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      sb_set_en  = 1'($urandom_range(0, 1));
      sb_set_idx = 5'($urandom_range(0, 11));
      rd_idx     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      #1;
      for (int p = 0; p < NR; p++) begin
        m_read(int'(rd_idx[p*AW +: AW]), ed, eb);
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_busy[p] !== eb) begin
          $display("FAIL random cyc=%0d port=%0d idx=%0d got %h/%b want %h/%b",
                   c, p, rd_idx[p*AW +: AW], rd_data[p*XLEN +: XLEN], rd_busy[p], ed, eb);
          errors++;
        end
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_data = {64'd0, 64'h1234_5678_9ABC_DEF0};
    cycle();
    idle_inputs();
    rst = 1'b1;
    rd_idx = {5'd5, 5'd5};
    cycle();
    checks++;
    if (init_done !== 1'b0 || rd_data !== 128'd0) begin
      $display("FAIL mid_run_rst init_done=%0b data=%h want 0/0", init_done, rd_data);
      errors++;
    end
    rst = 1'b0;
    for (int c = 0; c < NREG; c++) begin
      checks++;
      if (init_done !== 1'b0) begin
        $display("FAIL rerun_clear cyc=%0d init_done=%0b want 0", c, init_done);
        errors++;
      end
      cycle();
    end
    checks++;
    if (init_done !== 1'b1 || rd_data !== 128'd0) begin
      $display("FAIL x5_after_rst init_done=%0b data=%h want 1/0", init_done, rd_data);
      errors++;
    end
  endtask

  task automatic test_reset_mid_init();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < NREG; c++) begin
      checks++;
      if (init_done !== 1'b0) begin
        $display("FAIL restart_clear cyc=%0d init_done=%0b want 0", c, init_done);
        errors++;
      end
      cycle();
    end
    checks++;
    if (init_done !== 1'b1) begin
      $display("FAIL restart_done got %0b want 1", init_done);
      errors++;
    end
  endtask

  initial begin
    m_cleared = 0;
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = 64'd0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_port_priority();
    test_scoreboard();
    test_bypass();
    test_random();
    test_reset_mid_run();
    test_random();
    test_reset_mid_init();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
